// File: rtl/rr_sel_mux.sv
// N:1 selector with a single-entry registered output. Producers are merged either
// by an explicit select (MODE 0) or by round-robin arbitration (MODE 1).
module rr_sel_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] iData,
  input  logic [N-1:0]       iValid,
  output logic [N-1:0]       oReady,
  input  logic [SELW-1:0]    iS,
  output logic [WIDTH-1:0]   oData,
  output logic [SELW-1:0]    oSel,
  output logic               oValid,
  input  logic               iReady
);

  // Handshake: a word moves on channel k when iValid[k] && oReady[k], and leaves
  // the output register when oValid && iReady. oReady depends on the current
  // output occupancy (load = !oValid || iReady), so a consume and a new load
  // share one edge and the register sustains one word per cycle.

  localparam int NP = 1 << SELW;

  logic [WIDTH-1:0] ch_data [N];
  logic [NP-1:0]    valid_ext;
  logic [N-1:0]     cand_hi;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic             load;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  for (genvar k = 0; k < N; k++) begin : g_slice
    assign ch_data[k] = iData[k*WIDTH +: WIDTH];
  end

  // Zero padding makes an out-of-range select look like an idle channel.
  assign valid_ext = NP'(iValid);
  assign load      = !valid_q || iReady;

  function automatic logic [SELW-1:0] lowest_set(input logic [N-1:0] v);
    logic [SELW-1:0] idx;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) idx = SELW'(k);
    end
    return idx;
  endfunction

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_hi     = '0;
    if (MODE == 0) begin
      grant_idx   = iS;
      grant_valid = valid_ext[iS];
    end else begin
      // Channels above the last winner take priority; otherwise wrap to the lowest.
      for (int k = 0; k < N; k++) begin
        cand_hi[k] = iValid[k] && (SELW'(k) > ptr_q);
      end
      grant_valid = |iValid;
      grant_idx   = (|cand_hi) ? lowest_set(cand_hi) : lowest_set(iValid);
    end
  end

  assign oReady = (!rst && load && grant_valid) ? (N'(1) << grant_idx) : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        data_d = ch_data[grant_idx];
        sel_d  = grant_idx;
        if (MODE != 0) ptr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= SELW'(N - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign oData  = data_q;
  assign oSel   = sel_q;
  assign oValid = valid_q;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Bench for rr_sel_mux: four instances (select/round-robin, N=4 and N=3) share one
// set of inputs and are compared against a cycle-level behavioural model.
module tb_rr_sel_mux;

  logic         clk;
  logic         rst;
  logic [127:0] idata;
  logic [3:0]   ivalid;
  logic [1:0]   is;
  logic         iready;

  logic [3:0]  s4_ready, r4_ready;
  logic [2:0]  s3_ready, r3_ready;
  logic [31:0] s4_data, r4_data, s3_data, r3_data;
  logic [1:0]  s4_sel, r4_sel, s3_sel, r3_sel;
  logic        s4_valid, r4_valid, s3_valid, r3_valid;

  int checks = 0;
  int errors = 0;

  // Instance order: 0 = select N4, 1 = round-robin N4, 2 = select N3, 3 = round-robin N3.
  int          p_n    [4] = '{4, 4, 3, 3};
  int          p_mode [4] = '{0, 1, 0, 1};
  logic        m_valid[4];
  logic [31:0] m_data [4];
  int          m_sel  [4];
  int          m_ptr  [4];

  logic [3:0]  obs_ready[4];
  logic [31:0] obs_data [4];
  logic [1:0]  obs_sel  [4];
  logic        obs_valid[4];

  rr_sel_mux #(.WIDTH(32), .N(4), .MODE(0)) u_s4 (
    .clk(clk), .rst(rst), .iData(idata), .iValid(ivalid), .oReady(s4_ready),
    .iS(is), .oData(s4_data), .oSel(s4_sel), .oValid(s4_valid), .iReady(iready));
  rr_sel_mux #(.WIDTH(32), .N(4), .MODE(1)) u_r4 (
    .clk(clk), .rst(rst), .iData(idata), .iValid(ivalid), .oReady(r4_ready),
    .iS(is), .oData(r4_data), .oSel(r4_sel), .oValid(r4_valid), .iReady(iready));
  rr_sel_mux #(.WIDTH(32), .N(3), .MODE(0)) u_s3 (
    .clk(clk), .rst(rst), .iData(idata[95:0]), .iValid(ivalid[2:0]), .oReady(s3_ready),
    .iS(is), .oData(s3_data), .oSel(s3_sel), .oValid(s3_valid), .iReady(iready));
  rr_sel_mux #(.WIDTH(32), .N(3), .MODE(1)) u_r3 (
    .clk(clk), .rst(rst), .iData(idata[95:0]), .iValid(ivalid[2:0]), .oReady(r3_ready),
    .iS(is), .oData(r3_data), .oSel(r3_sel), .oValid(r3_valid), .iReady(iready));

  always_comb begin
    obs_ready[0] = s4_ready;  obs_ready[1] = r4_ready;
    obs_ready[2] = {1'b0, s3_ready};  obs_ready[3] = {1'b0, r3_ready};
    obs_data[0] = s4_data;  obs_data[1] = r4_data;  obs_data[2] = s3_data;  obs_data[3] = r3_data;
    obs_sel[0] = s4_sel;  obs_sel[1] = r4_sel;  obs_sel[2] = s3_sel;  obs_sel[3] = r3_sel;
    obs_valid[0] = s4_valid;  obs_valid[1] = r4_valid;
    obs_valid[2] = s3_valid;  obs_valid[3] = r3_valid;
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int model_grant(int i);
    if (p_mode[i] == 0) begin
      if (int'(is) < p_n[i] && ivalid[is]) return int'(is);
      return -1;
    end
    for (int s = 1; s <= p_n[i]; s++) begin
      int k = (m_ptr[i] + s) % p_n[i];
      if (ivalid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready(int i);
    int g;
    if (rst) return 4'b0;
    if (m_valid[i] && !iready) return 4'b0;
    g = model_grant(i);
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  // Advances one clock edge and moves the model to its post-edge state.
  task automatic tick();
    logic        n_valid[4];
    logic [31:0] n_data [4];
    int          n_sel  [4];
    int          n_ptr  [4];
    for (int i = 0; i < 4; i++) begin
      int g;
      n_valid[i] = m_valid[i];  n_data[i] = m_data[i];
      n_sel[i] = m_sel[i];  n_ptr[i] = m_ptr[i];
      g = model_grant(i);
      if (rst) begin
        n_valid[i] = 1'b0;  n_data[i] = '0;  n_sel[i] = 0;  n_ptr[i] = p_n[i] - 1;
      end else if (!m_valid[i] || iready) begin
        n_valid[i] = (g >= 0);
        if (g >= 0) begin
          n_data[i] = idata[g*32 +: 32];
          n_sel[i]  = g;
          if (p_mode[i] == 1) n_ptr[i] = g;
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = n_valid[i];  m_data[i] = n_data[i];
      m_sel[i] = n_sel[i];  m_ptr[i] = n_ptr[i];
    end
    #1;
  endtask

  task automatic set_channel_data();
    for (int k = 0; k < 4; k++) idata[k*32 +: 32] = {8{4'(k + 1)}};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;  ivalid = 4'hF;  iready = 1'b1;  is = 2'd0;
    set_channel_data();
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_ready[i] !== 4'b0) begin
          errors++;
          $display("FAIL reset_ready inst%0d: oReady=%b expected 0000", i, obs_ready[i]);
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_valid[i] !== 1'b0 || obs_data[i] !== 32'h0 || obs_sel[i] !== 2'd0) begin
          errors++;
          $display("FAIL reset_out inst%0d: valid=%b data=%h sel=%0d expected 0/0/0",
                   i, obs_valid[i], obs_data[i], obs_sel[i]);
        end
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (obs_ready[1] !== 4'b0001 || obs_ready[3] !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: r4 oReady=%b r3 oReady=%b expected 0001/0001",
               obs_ready[1], obs_ready[3]);
    end
    tick();
    checks++;
    if (obs_sel[1] !== 2'd0 || obs_valid[1] !== 1'b1 || obs_data[1] !== 32'h11111111) begin
      errors++;
      $display("FAIL reset_first_word: sel=%0d valid=%b data=%h expected 0/1/11111111",
               obs_sel[1], obs_valid[1], obs_data[1]);
    end
  endtask

  task automatic test_select();
    logic [31:0] exp_d;
    ivalid = 4'hF;  iready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      is = 2'(j);
      exp_d = {8{4'(j + 1)}};
      #1;
      checks++;
      if (obs_ready[0] !== 4'(1 << j)) begin
        errors++;
        $display("FAIL select_ready iS=%0d: oReady=%b expected %b", j, obs_ready[0], 4'(1 << j));
      end
      tick();
      checks++;
      if (obs_data[0] !== exp_d || obs_sel[0] !== 2'(j) || obs_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL select_out iS=%0d: data=%h sel=%0d valid=%b expected %h/%0d/1",
                 j, obs_data[0], obs_sel[0], obs_valid[0], exp_d, j);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_alt[4] = '{1, 3, 1, 3};
    rst = 1'b1;  tick();  rst = 1'b0;
    ivalid = 4'hF;  iready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs_sel[1] !== 2'(c % 4) || obs_valid[1] !== 1'b1) begin
        errors++;
        $display("FAIL rr_all cycle%0d: sel=%0d valid=%b expected %0d/1",
                 c, obs_sel[1], obs_valid[1], c % 4);
      end
    end
    ivalid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (obs_sel[1] !== 2'(exp_alt[c]) || obs_data[1] !== {8{4'(exp_alt[c] + 1)}}) begin
        errors++;
        $display("FAIL rr_sparse cycle%0d: sel=%0d data=%h expected %0d",
                 c, obs_sel[1], obs_data[1], exp_alt[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    ivalid = 4'hF;  iready = 1'b1;  is = 2'd2;
    tick();
    iready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      is = 2'($urandom_range(0, 3));
      idata[31:0] = $urandom;
      #1;
      checks++;
      if (obs_ready[0] !== 4'b0) begin
        errors++;
        $display("FAIL stall_ready cycle%0d: oReady=%b expected 0000", c, obs_ready[0]);
      end
      tick();
      checks++;
      if (obs_data[0] !== 32'h33333333 || obs_sel[0] !== 2'd2 || obs_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cycle%0d: data=%h sel=%0d valid=%b expected 33333333/2/1",
                 c, obs_data[0], obs_sel[0], obs_valid[0]);
      end
    end
    set_channel_data();
    is = 2'd1;  iready = 1'b1;
    #1;
    checks++;
    if (obs_ready[0] !== 4'b0010) begin
      errors++;
      $display("FAIL release_ready: oReady=%b expected 0010", obs_ready[0]);
    end
    tick();
    checks++;
    if (obs_data[0] !== 32'h22222222 || obs_sel[0] !== 2'd1 || obs_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL release_no_bubble: data=%h sel=%0d valid=%b expected 22222222/1/1",
               obs_data[0], obs_sel[0], obs_valid[0]);
    end
  endtask

  task automatic test_empty_npo2();
    ivalid = 4'hF;  iready = 1'b1;  is = 2'd0;
    tick();
    is = 2'd3;
    #1;
    checks++;
    if (obs_ready[2] !== 4'b0) begin
      errors++;
      $display("FAIL oob_select_ready: oReady=%b expected 000", obs_ready[2]);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (obs_valid[2] !== 1'b0 || obs_data[2] !== 32'h11111111 || obs_sel[2] !== 2'd0) begin
        errors++;
        $display("FAIL oob_select_drain cycle%0d: valid=%b data=%h sel=%0d expected 0/11111111/0",
                 c, obs_valid[2], obs_data[2], obs_sel[2]);
      end
    end
    ivalid = 4'b0010;
    tick();
    ivalid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (obs_ready[3] !== 4'b0) begin
        errors++;
        $display("FAIL rr_idle_ready cycle%0d: oReady=%b expected 000", c, obs_ready[3]);
      end
      tick();
      checks++;
      if (obs_valid[3] !== 1'b0) begin
        errors++;
        $display("FAIL rr_idle_valid cycle%0d: oValid=%b expected 0", c, obs_valid[3]);
      end
    end
    ivalid = 4'hF;
    #1;
    checks++;
    if (obs_ready[3] !== 4'b0100) begin
      errors++;
      $display("FAIL rr_ptr_kept: oReady=%b expected 100", obs_ready[3]);
    end
    tick();
    checks++;
    if (obs_sel[3] !== 2'd2 || obs_ready[3] !== 4'b0001) begin
      errors++;
      $display("FAIL rr_wrap_n3: sel=%0d oReady=%b expected 2/001", obs_sel[3], obs_ready[3]);
    end
    tick();
    checks++;
    if (obs_sel[3] !== 2'd0) begin
      errors++;
      $display("FAIL rr_wrap_n3_word: sel=%0d expected 0", obs_sel[3]);
    end
  endtask

  task automatic test_reset_mid();
    ivalid = 4'hF;  iready = 1'b1;
    tick();
    iready = 1'b0;
    tick();
    checks++;
    if (obs_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_held: oValid=%b expected 1", obs_valid[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs_ready[1] !== 4'b0) begin
      errors++;
      $display("FAIL midrst_ready: oReady=%b expected 0000", obs_ready[1]);
    end
    tick();
    checks++;
    if (obs_valid[1] !== 1'b0 || obs_data[1] !== 32'h0 || obs_sel[1] !== 2'd0) begin
      errors++;
      $display("FAIL midrst_drop: valid=%b data=%h sel=%0d expected 0/0/0",
               obs_valid[1], obs_data[1], obs_sel[1]);
    end
    rst = 1'b0;  iready = 1'b1;
    #1;
    checks++;
    if (obs_ready[1] !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr: oReady=%b expected 0001", obs_ready[1]);
    end
    tick();
    checks++;
    if (obs_sel[1] !== 2'd0 || obs_data[1] !== 32'h11111111) begin
      errors++;
      $display("FAIL midrst_next: sel=%0d data=%h expected 0/11111111", obs_sel[1], obs_data[1]);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_r;
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 39) == 0);
      ivalid = 4'($urandom);
      is     = 2'($urandom);
      iready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) idata[k*32 +: 32] = $urandom;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_r = model_ready(i);
        checks++;
        if (obs_ready[i] !== exp_r) begin
          errors++;
          $display("FAIL rand_ready c%0d inst%0d: oReady=%b expected %b", c, i, obs_ready[i], exp_r);
        end
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_valid[i] !== m_valid[i] || obs_data[i] !== m_data[i] || obs_sel[i] !== 2'(m_sel[i])) begin
          errors++;
          $display("FAIL rand_out c%0d inst%0d: valid=%b data=%h sel=%0d expected %b/%h/%0d",
                   c, i, obs_valid[i], obs_data[i], obs_sel[i], m_valid[i], m_data[i], m_sel[i]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;  ivalid = '0;  is = '0;  iready = 1'b0;  idata = '0;
    test_reset();
    test_select();
    test_round_robin();
    test_backpressure();
    test_empty_npo2();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
